k_alu_issue: RTL and testbench

//  - Operand-issue / writeback sequencer on the requesting side of the K_ALU operand interface.
//  - Accepts one instruction word at a time and reads two source registers from a local register file.
//  - Drives opA/opB/selector to the ALU, waits for its completion strobe, then writes the result to the destination register.
//  - Exactly one instruction is in flight at a time; there is no forwarding and there are no hazards.

---
 rtl/k_alu_pkg.sv | 36 +++
 rtl/k_regfile.sv | 34 +++
 rtl/k_alu_issue.sv | 102 ++++++++++
 tb/tb_k_alu_issue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/k_alu_pkg.sv
// k_alu_pkg: op codes, FSM encoding and instruction field offsets shared by the K_ALU issue slice
package k_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_SH8 = 3'b010;
    localparam logic [2:0] OP_SH16 = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPND,
        S_ISSUE,
        S_WB
    } state_t;

    // Instruction layout is {op[2:0], rd, ra, rb}, MSB first; rb sits at bit 0
    function automatic int ra_lsb(input int aw);
        return aw;
    endfunction

    function automatic int rd_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int op_lsb(input int aw);
        return 3 * aw;
    endfunction

    // 110 and 111 are reserved
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/k_regfile.sv
// k_regfile: 2 async read ports + debug read port, 1 sync write port, r0 hard zero, async clear
module k_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [2**REG_AW];

    // Storage; r0 is never written so it keeps its cleared value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/k_alu_issue.sv
// k_alu_issue: single-in-flight operand issue / writeback sequencer for the K_ALU
// Optional macro K_ALU_DIVZERO_TRAP_EN: divide by a zero operand B traps locally (err + all-ones result)
module k_alu_issue
    import k_alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_op_a,
    output logic [DATA_W-1:0]  alu_op_b,
    output logic [2:0]         alu_sel,
    output logic               alu_req,
    input  logic               alu_done,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               err,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t state, state_nx;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0] ra_data, rb_data, result_q;
    logic [2:0] op;
    logic [REG_AW-1:0] rd, ra, rb;
    logic illegal, trap;

    assign op = instr_q[op_lsb(REG_AW) +: 3];
    assign rd = instr_q[rd_lsb(REG_AW) +: REG_AW];
    assign ra = instr_q[ra_lsb(REG_AW) +: REG_AW];
    assign rb = instr_q[0 +: REG_AW];
    assign illegal = op_illegal(op);

`ifdef K_ALU_DIVZERO_TRAP_EN
    assign trap = op == OP_DIV && rb_data == '0;
`else
    assign trap = 1'b0;
`endif

    assign instr_ready = state == S_IDLE;
    assign alu_req = state == S_ISSUE;
    assign wb_valid = state == S_WB;
    assign err = state == S_OPND && (illegal || trap);
    assign wb_addr = rd;
    assign wb_data = result_q;

    k_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra),
        .rb_addr (rb),
        .dbg_addr(dbg_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .dbg_data(dbg_data),
        .we      (wb_valid),
        .wa      (rd),
        .wd      (result_q)
    );

    // Next state: illegal ops abort in OPND, a trapped divide skips the ALU straight to writeback
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = instr_valid ? S_OPND : S_IDLE;
            S_OPND:  state_nx = illegal ? S_IDLE : trap ? S_WB : S_ISSUE;
            S_ISSUE: state_nx = alu_done ? S_WB : S_ISSUE;
            S_WB:    state_nx = S_IDLE;
        endcase
    end

    // State, latched instruction, operand registers and captured result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            alu_op_a <= '0;
            alu_op_b <= '0;
            alu_sel  <= '0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            if (instr_ready && instr_valid) instr_q <= instr;
            if (state == S_OPND) begin
                alu_op_a <= ra_data;
                alu_op_b <= rb_data;
                alu_sel  <= op;
            end
            if (state == S_OPND && trap) result_q <= '1;
            else if (alu_req && alu_done) result_q <= alu_result;
        end
    end

endmodule

// File: tb/tb_k_alu_issue.sv
// tb_k_alu_issue: directed self-checking bench for k_alu_issue; the bench plays the ALU
module tb_k_alu_issue;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int IW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid = 1'b0;
    logic [IW-1:0] instr = '0;
    logic alu_done = 1'b0;
    logic [DW-1:0] alu_result = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic instr_ready, alu_req, wb_valid, err;
    logic [DW-1:0] alu_op_a, alu_op_b, wb_data, dbg_data;
    logic [2:0] alu_sel;
    logic [AW-1:0] wb_addr;

    int checks = 0;
    int failures = 0;

    k_alu_issue #(.DATA_W(DW), .REG_AW(AW), .INSTR_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_op_a   (alu_op_a),
        .alu_op_b   (alu_op_b),
        .alu_sel    (alu_sel),
        .alu_req    (alu_req),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input logic [3:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        @(negedge clk);
        chk(tag, dbg_data, exp);
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE; returns one cycle after acceptance (in OPND)
    task automatic accept(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
        chk("ready_before_accept", instr_ready, 1);
        instr = {op, rd, ra, rb};
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("ready_low_opnd", instr_ready, 0);
    endtask

    task automatic legal_opnd();
        chk("err_opnd", err, 0);
        chk("req_opnd", alu_req, 0);
        cyc();
    endtask

    // Act as the ALU: alu_req is expected high for lat cycles, done strobed in the last
    task automatic alu_run(input int lat, input logic [31:0] res, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [2:0] esel, input logic [3:0] ewa, input logic [31:0] ewd);
        for (int i = 0; i < lat; i++) begin
            chk("req_issue", alu_req, 1);
            chk("op_a", alu_op_a, ea);
            chk("op_b", alu_op_b, eb);
            chk("sel", alu_sel, esel);
            chk("ready_issue", instr_ready, 0);
            chk("wb_issue", wb_valid, 0);
            if (i == lat - 1) begin
                alu_done = 1'b1;
                alu_result = res;
            end
            cyc();
        end
        alu_done = 1'b0;
        alu_result = '0;
        chk("wb_valid", wb_valid, 1);
        chk("wb_addr", wb_addr, ewa);
        chk("wb_data", wb_data, ewd);
        chk("req_wb", alu_req, 0);
        chk("ready_wb", instr_ready, 0);
        cyc();
        chk("ready_after_wb", instr_ready, 1);
        chk("wb_after", wb_valid, 0);
    endtask

    task automatic op_run(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                          input int lat, input logic [31:0] res, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] ewd);
        accept(op, rd, ra, rb);
        legal_opnd();
        alu_run(lat, res, ea, eb, op, rd, ewd);
    endtask

    initial begin
        #2;
        chk("rst_ready", instr_ready, 1);
        chk("rst_req", alu_req, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_op_a", alu_op_a, 0);
        chk("rst_op_b", alu_op_b, 0);
        chk("rst_sel", alu_sel, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        op_run(3'b000, 4'd1, 4'd0, 4'd0, 1, 32'd5, 32'd0, 32'd0, 32'd5);
        op_run(3'b000, 4'd2, 4'd0, 4'd0, 1, 32'd3, 32'd0, 32'd0, 32'd3);
        dbg(4'd1, 32'd5, "dbg_r1");
        dbg(4'd2, 32'd3, "dbg_r2");

        op_run(3'b000, 4'd3, 4'd1, 4'd2, 1, 32'd8, 32'd5, 32'd3, 32'd8);
        dbg(4'd3, 32'd8, "dbg_r3");

        op_run(3'b100, 4'd4, 4'd1, 4'd2, 20, 32'd1, 32'd5, 32'd3, 32'd1);
        dbg(4'd4, 32'd1, "dbg_r4");

        accept(3'b111, 4'd5, 4'd1, 4'd2);
        chk("illegal_err", err, 1);
        chk("illegal_req", alu_req, 0);
        chk("illegal_wb", wb_valid, 0);
        cyc();
        chk("illegal_err_drop", err, 0);
        chk("illegal_ready", instr_ready, 1);
        chk("illegal_req2", alu_req, 0);
        chk("illegal_wb2", wb_valid, 0);
        cyc();
        chk("illegal_wb3", wb_valid, 0);
        chk("illegal_req3", alu_req, 0);

        alu_done = 1'b1;
        alu_result = 32'hBAD;
        cyc();
        alu_done = 1'b0;
        chk("idle_done_ready", instr_ready, 1);
        chk("idle_done_req", alu_req, 0);
        chk("idle_done_wb", wb_valid, 0);
        dbg(4'd5, 32'd0, "dbg_r5_untouched");

        op_run(3'b000, 4'd0, 4'd1, 4'd2, 1, 32'hDEAD, 32'd5, 32'd3, 32'hDEAD);
        dbg(4'd0, 32'd0, "dbg_r0");

        accept(3'b100, 4'd5, 4'd1, 4'd0);
`ifdef K_ALU_DIVZERO_TRAP_EN
        chk("dz_err", err, 1);
        chk("dz_req", alu_req, 0);
        cyc();
        chk("dz_wb_valid", wb_valid, 1);
        chk("dz_wb_addr", wb_addr, 5);
        chk("dz_wb_data", wb_data, 32'hFFFF_FFFF);
        chk("dz_req2", alu_req, 0);
        cyc();
        chk("dz_ready", instr_ready, 1);
        dbg(4'd5, 32'hFFFF_FFFF, "dbg_r5_dz");
`else
        legal_opnd();
        alu_run(2, 32'h1234, 32'd5, 32'd0, 3'b100, 4'd5, 32'h1234);
        dbg(4'd5, 32'h1234, "dbg_r5_div0");
`endif

        op_run(3'b101, 4'd6, 4'd3, 4'd4, 3, 32'd7, 32'd8, 32'd1, 32'd7);
        dbg(4'd6, 32'd7, "dbg_r6");

        accept(3'b000, 4'd7, 4'd1, 4'd2);
        legal_opnd();
        chk("pre_rst_req", alu_req, 1);
        chk("pre_rst_op_a", alu_op_a, 5);
        #3;
        rst = 1'b1;
        #2;
        chk("arst_req", alu_req, 0);
        chk("arst_ready", instr_ready, 1);
        chk("arst_op_a", alu_op_a, 0);
        chk("arst_op_b", alu_op_b, 0);
        chk("arst_sel", alu_sel, 0);
        chk("arst_wb", wb_valid, 0);
        chk("arst_err", err, 0);
        chk("arst_wb_addr", wb_addr, 0);
        chk("arst_wb_data", wb_data, 0);
        for (int a = 0; a < 16; a++) dbg(a[3:0], 32'd0, "arst_dbg");
        rst = 1'b0;
        alu_done = 1'b1;
        alu_result = 32'h55;
        cyc();
        alu_done = 1'b0;
        chk("stale_req", alu_req, 0);
        chk("stale_wb", wb_valid, 0);
        chk("stale_ready", instr_ready, 1);
        cyc();
        chk("stale_wb2", wb_valid, 0);
        dbg(4'd7, 32'd0, "stale_dbg_r7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
